// File: rtl/kernel_mem_stream_if.sv
// Host-write and column-read handshake bundle of the kernel store.
// rd_data_last exists only when KERNEL_MEM_STREAM_LAST_EN is defined.
interface kernel_mem_stream_if #(
   parameter int DATA_W     = 1024,
   parameter int MEM_AWIDTH = 10,
   parameter int REPEAT_W   = 8
);
   logic [MEM_AWIDTH-1:0] wr_cfg_end;
   logic                  wr_cfg_set;
   logic [DATA_W-1:0]     wr_data;
   logic                  wr_data_val;
   logic                  wr_data_rdy;
   logic [MEM_AWIDTH-1:0] rd_cfg_start;
   logic [MEM_AWIDTH-1:0] rd_cfg_end;
   logic [REPEAT_W-1:0]   rd_cfg_repeat;
   logic                  rd_cfg_set;
   logic                  rd_busy;
   logic                  rd_done;
   logic [DATA_W-1:0]     rd_bias;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_data_val;
   logic                  rd_data_rdy;
`ifdef KERNEL_MEM_STREAM_LAST_EN
   logic                  rd_data_last;
`endif

   modport master (
`ifdef KERNEL_MEM_STREAM_LAST_EN
      input  rd_data_last,
`endif
      output wr_cfg_end,
      output wr_cfg_set,
      output wr_data,
      output wr_data_val,
      input  wr_data_rdy,
      output rd_cfg_start,
      output rd_cfg_end,
      output rd_cfg_repeat,
      output rd_cfg_set,
      input  rd_busy,
      input  rd_done,
      input  rd_bias,
      input  rd_data,
      input  rd_data_val,
      output rd_data_rdy
   );

   modport slave (
`ifdef KERNEL_MEM_STREAM_LAST_EN
      output rd_data_last,
`endif
      input  wr_cfg_end,
      input  wr_cfg_set,
      input  wr_data,
      input  wr_data_val,
      output wr_data_rdy,
      input  rd_cfg_start,
      input  rd_cfg_end,
      input  rd_cfg_repeat,
      input  rd_cfg_set,
      output rd_busy,
      output rd_done,
      output rd_bias,
      output rd_data,
      output rd_data_val,
      input  rd_data_rdy
   );
endinterface

// File: rtl/kernel_mem_stream.sv
// Circular kernel/bias store with a multi-pass valid/ready read stream.
// Define KERNEL_MEM_STREAM_LAST_EN to add rd_data_last (end-of-pass flag).
module kernel_mem_stream #(
   parameter int GROUP_NB   = 4,
   parameter int KER_WIDTH  = 16,
   parameter int DEPTH_NB   = 16,
   parameter int MEM_AWIDTH = 10,
   parameter int REPEAT_W   = 8
) (
   input logic                clk,
   input logic                rst,
   kernel_mem_stream_if.slave bus
);
   localparam int DATA_W    = GROUP_NB * KER_WIDTH * DEPTH_NB;
   localparam int MEM_DEPTH = 1 << MEM_AWIDTH;

   typedef enum logic [1:0] {
      IDLE,
      BIAS,
      STREAM
   } rd_state_e;

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   logic [MEM_AWIDTH-1:0] wr_ptr;
   logic [MEM_AWIDTH-1:0] wr_end;
   logic                  wr_ptr_wrap;
   logic                  wr_end_wrap;
   logic                  wr_rdy;
   logic                  wr_fire;

   rd_state_e             state_q;
   rd_state_e             state_d;
   logic [MEM_AWIDTH-1:0] start_q;
   logic [MEM_AWIDTH-1:0] end_q;
   logic [MEM_AWIDTH-1:0] ptr_q;
   logic [MEM_AWIDTH-1:0] rd_addr;
   logic [REPEAT_W-1:0]   pass_q;
   logic                  issued_q;
   logic                  val_q;
   logic                  issue;
   logic                  job_done;
   logic                  pass_end;
   logic [DATA_W-1:0]     rd_word;
   logic [DATA_W-1:0]     bias_q;
   logic [DATA_W-1:0]     data_q;
`ifdef KERNEL_MEM_STREAM_LAST_EN
   logic                  last_q;
`endif

   // Full when pointers match but sit on different laps.
   assign wr_rdy  = !((wr_ptr_wrap != wr_end_wrap) && (wr_ptr == wr_end));
   assign wr_fire = bus.wr_data_val && wr_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         wr_ptr_wrap <= 1'b0;
         wr_end      <= '0;
         wr_end_wrap <= 1'b1;
      end else begin
         if (bus.wr_cfg_set) begin
            wr_end <= bus.wr_cfg_end;
            if (wr_end >= bus.wr_cfg_end) begin
               wr_end_wrap <= !wr_end_wrap;
            end
         end
         if (wr_fire) begin
            wr_ptr <= wr_ptr + MEM_AWIDTH'(1);
            if (&wr_ptr) begin
               wr_ptr_wrap <= !wr_ptr_wrap;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   // One read port: bias address during BIAS, kernel pointer otherwise.
   assign rd_word  = mem[rd_addr];
   assign pass_end = (ptr_q == end_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      job_done = 1'b0;
      rd_addr  = ptr_q;
      unique case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         BIAS: begin
            rd_addr = start_q;
            state_d = STREAM;
         end
         STREAM: begin
            issue    = !issued_q && (!val_q || bus.rd_data_rdy);
            job_done = issued_q && (!val_q || bus.rd_data_rdy);
            if (job_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A new job aborts whatever is running, including its completion.
      if (bus.rd_cfg_set) begin
         state_d  = BIAS;
         issue    = 1'b0;
         job_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start_q  <= '0;
         end_q    <= '0;
         ptr_q    <= '0;
         pass_q   <= '0;
         issued_q <= 1'b0;
         val_q    <= 1'b0;
         bias_q   <= '0;
         data_q   <= '0;
`ifdef KERNEL_MEM_STREAM_LAST_EN
         last_q   <= 1'b0;
`endif
      end else if (bus.rd_cfg_set) begin
         start_q  <= bus.rd_cfg_start;
         end_q    <= bus.rd_cfg_end;
         pass_q   <= bus.rd_cfg_repeat;
         ptr_q    <= bus.rd_cfg_start + MEM_AWIDTH'(1);
         issued_q <= (bus.rd_cfg_start == bus.rd_cfg_end);
         val_q    <= 1'b0;
      end else begin
         if (state_q == BIAS) begin
            bias_q <= rd_word;
         end
         if (issue) begin
            data_q <= rd_word;
            val_q  <= 1'b1;
`ifdef KERNEL_MEM_STREAM_LAST_EN
            last_q <= pass_end;
`endif
            if (!pass_end) begin
               ptr_q <= ptr_q + MEM_AWIDTH'(1);
            end else if (pass_q != '0) begin
               pass_q <= pass_q - REPEAT_W'(1);
               ptr_q  <= start_q + MEM_AWIDTH'(1);
            end else begin
               issued_q <= 1'b1;
            end
         end else if (bus.rd_data_rdy) begin
            val_q <= 1'b0;
         end
      end
   end

   assign bus.wr_data_rdy = wr_rdy;
   assign bus.rd_busy     = (state_q != IDLE);
   assign bus.rd_done     = job_done;
   assign bus.rd_bias     = bias_q;
   assign bus.rd_data     = data_q;
   assign bus.rd_data_val = val_q;
`ifdef KERNEL_MEM_STREAM_LAST_EN
   assign bus.rd_data_last = last_q;
`endif

endmodule
